// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: IF/MEM request ports and the single memory port.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              stall_if;
  logic              stall_mem;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_done, stall_if, stall_mem,
           mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_done, stall_if, stall_mem,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: one single-ported memory shared by IF and MEM, one access at a time.
// Define ARB_FAIR_EN to alternate priority between IF and data on contention;
// otherwise data always wins a tie.
module unified_mem_arbiter #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic                  clk,
  input logic                  rst,
  unified_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;
  localparam logic [3:0] LAT = 4'(MEM_LAT);
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              if_valid_q, if_valid_d;
  logic              d_done_q, d_done_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              gnt_data, gnt_if;
`ifdef ARB_FAIR_EN
  logic last_q, last_d;
  // IF wins a tie when the previous grant went to data (last_q=0)
  always_comb begin
    gnt_if   = bus.if_req & (~bus.d_req | ~last_q);
    gnt_data = bus.d_req & ~gnt_if;
    last_d   = (state_q == IDLE && (gnt_if | gnt_data)) ? gnt_if : last_q;
  end
  // remember who was granted last, 1 = IF
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b0;
    else     last_q <= last_d;
  end
`else
  // fixed priority: data over instruction
  always_comb begin
    gnt_data = bus.d_req;
    gnt_if   = bus.if_req & ~bus.d_req;
  end
`endif
  // accept in IDLE, count down the latency, capture read data and pulse on completion
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    if_valid_d  = 1'b0;
    d_done_d    = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if (state_q == IDLE) begin
      if (gnt_data | gnt_if) begin
        state_d     = gnt_data ? BUSY_D : BUSY_I;
        cnt_d       = LAT;
        we_d        = gnt_data & bus.d_we;
        mem_en_d    = 1'b1;
        mem_we_d    = gnt_data & bus.d_we;
        mem_addr_d  = gnt_data ? bus.d_addr : bus.if_addr;
        mem_wdata_d = gnt_data ? bus.d_wdata : mem_wdata_q;
      end
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      state_d    = IDLE;
      if_valid_d = state_q == BUSY_I;
      d_done_d   = state_q == BUSY_D;
      if_rdata_d = (state_q == BUSY_I) ? bus.mem_rdata : if_rdata_q;
      d_rdata_d  = (state_q == BUSY_D && !we_q) ? bus.mem_rdata : d_rdata_q;
    end
  end
  // state and output registers; reset abandons any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      if_valid_q  <= 1'b0;
      d_done_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      if_valid_q  <= if_valid_d;
      d_done_q    <= d_done_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_done    = d_done_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.stall_if  = bus.if_req & ~if_valid_q;
  assign bus.stall_mem = bus.d_req & ~d_done_q;
endmodule
